// File: rtl/sys_sum_acc.sv
// sys_sum_acc: sums DepthIn consecutive rows of NumOfNerves signed elements
// per channel, then streams the saturated sums out OutLanes elements per
// beat, highest nerve index first. A shadow buffer decouples accumulation
// from draining so a new group can build while the previous one is emitted.
//
// Ports:
//   clk        clock, all logic on posedge
//   res        synchronous active-high reset
//   in_valid   row presented
//   in_start   first row of a group
//   in_data    row elements, signed BitSize each
//   in_ready   row accepted when in_valid && in_ready
//   out_ready  downstream accepts current beat
//   out_valid  beat presented
//   out_start  first beat of a group
//   out_last   last beat of a group
//   out_data   OutLanes saturated sums
//   sat_flag   sticky, set once any presented element was clamped
module sys_sum_acc #(
  parameter int unsigned BitSize     = 8,
  parameter int unsigned AccSize     = 16,
  parameter int unsigned NumOfNerves = 4,
  parameter int unsigned DepthIn     = 2,
  parameter int unsigned OutLanes    = 1
) (
  input  logic                                clk,
  input  logic                                res,
  input  logic                                in_valid,
  input  logic                                in_start,
  input  logic [NumOfNerves-1:0][BitSize-1:0] in_data,
  output logic                                in_ready,
  input  logic                                out_ready,
  output logic                                out_valid,
  output logic                                out_start,
  output logic                                out_last,
  output logic [OutLanes-1:0][BitSize-1:0]    out_data,
  output logic                                sat_flag
);

  localparam int unsigned Beats   = NumOfNerves / OutLanes;
  localparam int unsigned BeatW   = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned CntW    = $clog2(DepthIn + 1);
  localparam int unsigned NerveW  = (NumOfNerves > 1) ? $clog2(NumOfNerves) : 1;

  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
  localparam logic [CntW-1:0]  FullCnt  = CntW'(DepthIn);

  // Clamp bounds in accumulator width; the minimum is the bitwise inverse of the maximum.
  localparam logic signed [AccSize-1:0] SatMax = AccSize'((64'(1) << (BitSize - 1)) - 64'(1));
  localparam logic signed [AccSize-1:0] SatMin = ~SatMax;

  typedef enum logic { ST_ACC,  ST_HOLD  } in_state_e;
  typedef enum logic { ST_IDLE, ST_DRAIN } out_state_e;

  in_state_e                  in_state_q,  in_state_d;
  out_state_e                 out_state_q, out_state_d;
  logic signed [AccSize-1:0]  acc_q    [NumOfNerves];
  logic signed [AccSize-1:0]  acc_d    [NumOfNerves];
  logic signed [AccSize-1:0]  shadow_q [NumOfNerves];
  logic signed [AccSize-1:0]  shadow_d [NumOfNerves];
  logic signed [AccSize-1:0]  row_sum  [NumOfNerves];
  logic [CntW-1:0]            cnt_q, cnt_d, cnt_new;
  logic [BeatW-1:0]           beat_q, beat_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_start_q, out_start_d;
  logic                       out_last_q, out_last_d;
  logic [OutLanes-1:0][BitSize-1:0] out_data_q, out_data_d;
  logic                       sat_q, sat_d;

  logic                       row_used;
  logic                       shadow_free;
  logic                       shadow_load;
  logic                       handshake;
  logic                       beat_sat;
  logic [NerveW-1:0]          nerve_idx;

  function automatic logic signed [AccSize-1:0] sext(input logic [BitSize-1:0] v);
    return AccSize'($signed(v));
  endfunction

  function automatic logic [BitSize-1:0] clamp(input logic signed [AccSize-1:0] v);
    if (v > SatMax) return SatMax[BitSize-1:0];
    if (v < SatMin) return SatMin[BitSize-1:0];
    return v[BitSize-1:0];
  endfunction

  function automatic logic is_sat(input logic signed [AccSize-1:0] v);
    return (v > SatMax) || (v < SatMin);
  endfunction

  // Next-state logic for both FSMs, accumulators, shadow and registered outputs.
  always_comb begin
    in_state_d  = in_state_q;
    out_state_d = out_state_q;
    acc_d       = acc_q;
    shadow_d    = shadow_q;
    row_sum     = acc_q;
    cnt_d       = cnt_q;
    cnt_new     = cnt_q;
    beat_d      = beat_q;
    row_used    = 1'b0;
    shadow_load = 1'b0;
    beat_sat    = 1'b0;
    nerve_idx   = '0;
    out_data_d  = '0;

    // The shadow can take new sums if idle or its final beat leaves this edge.
    shadow_free = !out_valid_q || (out_valid_q && out_ready && out_last_q);
    handshake   = out_valid_q && out_ready;

    unique case (in_state_q)
      ST_ACC: begin
        if (in_valid) begin
          if (in_start) begin
            row_used = 1'b1;
            cnt_new  = CntW'(1);
            for (int unsigned i = 0; i < NumOfNerves; i++) row_sum[i] = sext(in_data[i]);
          end else if (cnt_q != '0) begin
            row_used = 1'b1;
            cnt_new  = cnt_q + CntW'(1);
            for (int unsigned i = 0; i < NumOfNerves; i++) row_sum[i] = acc_q[i] + sext(in_data[i]);
          end
          // Start-less rows outside a group fall through untouched.
          if (row_used) begin
            acc_d = row_sum;
            cnt_d = cnt_new;
            if (cnt_new == FullCnt) begin
              if (shadow_free) begin
                shadow_d    = row_sum;
                shadow_load = 1'b1;
                cnt_d       = '0;
              end else begin
                in_state_d = ST_HOLD;
              end
            end
          end
        end
      end
      ST_HOLD: begin
        if (shadow_free) begin
          shadow_d    = acc_q;
          shadow_load = 1'b1;
          cnt_d       = '0;
          in_state_d  = ST_ACC;
        end
      end
      default: in_state_d = ST_ACC;
    endcase

    // A shadow load always wins; it can only coincide with the final handshake.
    if (shadow_load) begin
      out_state_d = ST_DRAIN;
      beat_d      = '0;
    end else if (handshake) begin
      if (beat_q == LastBeat) begin
        out_state_d = ST_IDLE;
        beat_d      = '0;
      end else begin
        beat_d = beat_q + BeatW'(1);
      end
    end

    in_ready_d  = (in_state_d == ST_ACC);
    out_valid_d = (out_state_d == ST_DRAIN);
    out_start_d = out_valid_d && (beat_d == '0);
    out_last_d  = out_valid_d && (beat_d == LastBeat);

    // Highest nerve first: lane j of beat b carries nerve N-1-(b*OutLanes+j).
    if (out_valid_d) begin
      for (int unsigned j = 0; j < OutLanes; j++) begin
        nerve_idx     = NerveW'(NumOfNerves - 1 - (32'(beat_d) * OutLanes + j));
        out_data_d[j] = clamp(shadow_d[nerve_idx]);
        beat_sat      = beat_sat | is_sat(shadow_d[nerve_idx]);
      end
    end
    sat_d = sat_q | beat_sat;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (res) begin
      in_state_q  <= ST_ACC;
      out_state_q <= ST_IDLE;
      for (int unsigned i = 0; i < NumOfNerves; i++) begin
        acc_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      cnt_q       <= '0;
      beat_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      for (int unsigned i = 0; i < NumOfNerves; i++) begin
        acc_q[i]    <= acc_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_sys_sum_acc.sv
// Directed bench for sys_sum_acc: basic sums, saturation, backpressure with
// HOLD, restart/drop behaviour, a two-lane instance and reset mid-drain.
module tb_sys_sum_acc;

  logic            clk;
  logic            res;
  logic            in_valid;
  logic            in_start;
  logic [3:0][7:0] in_data;
  logic            in_ready;
  logic            out_ready;
  logic            out_valid;
  logic            out_start;
  logic            out_last;
  logic [0:0][7:0] out_data;
  logic            sat_flag;

  logic            in_ready2;
  logic            out_valid2;
  logic            out_start2;
  logic            out_last2;
  logic [1:0][7:0] out_data2;
  logic            sat_flag2;

  int n_checks = 0;
  int n_fail   = 0;

  sys_sum_acc #(.BitSize(8), .AccSize(16), .NumOfNerves(4), .DepthIn(2), .OutLanes(1)) dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_start(in_start), .in_data(in_data),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid), .out_start(out_start),
    .out_last(out_last), .out_data(out_data), .sat_flag(sat_flag)
  );

  sys_sum_acc #(.BitSize(8), .AccSize(16), .NumOfNerves(4), .DepthIn(2), .OutLanes(2)) dut2 (
    .clk(clk), .res(res), .in_valid(in_valid), .in_start(in_start), .in_data(in_data),
    .in_ready(in_ready2), .out_ready(out_ready), .out_valid(out_valid2), .out_start(out_start2),
    .out_last(out_last2), .out_data(out_data2), .sat_flag(sat_flag2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][7:0] row(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic send(input logic start, input logic [3:0][7:0] data);
    in_valid = 1'b1;
    in_start = start;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic do_reset();
    res       = 1'b1;
    in_valid  = 1'b0;
    in_start  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    res = 1'b0;
  endtask

  task automatic beat(input string tag, input int d, input logic s, input logic l);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_data"},  int'($signed(out_data[0])), d);
    check({tag, "_start"}, int'(s ? out_start : out_start), int'(s));
    check({tag, "_last"},  int'(out_last), int'(l));
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", int'(out_valid), 0);
    check("rst_start", int'(out_start), 0);
    check("rst_last",  int'(out_last), 0);
    check("rst_data",  int'(out_data[0]), 0);
    check("rst_ready", int'(in_ready), 1);
    check("rst_sat",   int'(sat_flag), 0);

    // Basic: beats 44,33,22,11 starting one cycle after row 2
    send(1'b1, row(1, 2, 3, 4));
    check("basic_novalid_row1", int'(out_valid), 0);
    send(1'b0, row(10, 20, 30, 40));
    beat("basic_b0", 44, 1'b1, 1'b0);
    check("lane2_b0_valid", int'(out_valid2), 1);
    check("lane2_b0_d0", int'($signed(out_data2[0])), 44);
    check("lane2_b0_d1", int'($signed(out_data2[1])), 33);
    check("lane2_b0_start", int'(out_start2), 1);
    check("lane2_b0_last", int'(out_last2), 0);
    tick();
    beat("basic_b1", 33, 1'b0, 1'b0);
    check("lane2_b1_d0", int'($signed(out_data2[0])), 22);
    check("lane2_b1_d1", int'($signed(out_data2[1])), 11);
    check("lane2_b1_start", int'(out_start2), 0);
    check("lane2_b1_last", int'(out_last2), 1);
    tick();
    beat("basic_b2", 22, 1'b0, 1'b0);
    check("lane2_done", int'(out_valid2), 0);
    tick();
    beat("basic_b3", 11, 1'b0, 1'b1);
    tick();
    check("basic_end_valid", int'(out_valid), 0);
    check("basic_sat", int'(sat_flag), 0);

    // Saturation: sums 200,-200,10,0 -> beats 0,10,-128,127
    do_reset();
    send(1'b1, row(100, -100, 5, 0));
    send(1'b0, row(100, -100, 5, 0));
    beat("sat_b0", 0, 1'b1, 1'b0);
    check("sat_b0_flag", int'(sat_flag), 0);
    tick();
    beat("sat_b1", 10, 1'b0, 1'b0);
    tick();
    beat("sat_b2", -128, 1'b0, 1'b0);
    check("sat_b2_flag", int'(sat_flag), 1);
    tick();
    beat("sat_b3", 127, 1'b0, 1'b1);
    tick();
    tick();
    check("sat_sticky", int'(sat_flag), 1);

    // Backpressure: group 1 held, group 2 parks in HOLD
    do_reset();
    out_ready = 1'b0;
    send(1'b1, row(1, 2, 3, 4));
    send(1'b0, row(10, 20, 30, 40));
    beat("bp_g1_b0", 44, 1'b1, 1'b0);
    send(1'b1, row(1, 1, 1, 1));
    check("bp_ready_mid_g2", int'(in_ready), 1);
    send(1'b0, row(2, 2, 2, 2));
    check("bp_ready_hold", int'(in_ready), 0);
    beat("bp_g1_b0_held1", 44, 1'b1, 1'b0);
    tick();
    tick();
    beat("bp_g1_b0_held2", 44, 1'b1, 1'b0);
    check("bp_ready_hold2", int'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    beat("bp_g1_b1", 33, 1'b0, 1'b0);
    tick();
    beat("bp_g1_b2", 22, 1'b0, 1'b0);
    tick();
    beat("bp_g1_b3", 11, 1'b0, 1'b1);
    check("bp_ready_before_last", int'(in_ready), 0);
    tick();
    check("bp_ready_after_last", int'(in_ready), 1);
    beat("bp_g2_b0", 3, 1'b1, 1'b0);
    tick();
    beat("bp_g2_b1", 3, 1'b0, 1'b0);
    tick();
    beat("bp_g2_b2", 3, 1'b0, 1'b0);
    tick();
    beat("bp_g2_b3", 3, 1'b0, 1'b1);
    tick();
    check("bp_end_valid", int'(out_valid), 0);

    // Restart: second start row discards the first partial group
    do_reset();
    send(1'b1, row(1, 1, 1, 1));
    send(1'b1, row(2, 2, 2, 2));
    check("rs_novalid", int'(out_valid), 0);
    send(1'b0, row(3, 3, 3, 3));
    beat("rs_b0", 5, 1'b1, 1'b0);
    tick();
    beat("rs_b1", 5, 1'b0, 1'b0);
    tick();
    beat("rs_b2", 5, 1'b0, 1'b0);
    tick();
    beat("rs_b3", 5, 1'b0, 1'b1);
    tick();
    // Start-less row while idle is dropped
    send(1'b0, row(9, 9, 9, 9));
    check("drop_v0", int'(out_valid), 0);
    tick();
    check("drop_v1", int'(out_valid), 0);
    send(1'b0, row(7, 7, 7, 7));
    check("drop_v2", int'(out_valid), 0);
    send(1'b1, row(1, 2, 3, 4));
    send(1'b0, row(10, 20, 30, 40));
    beat("drop_after_b0", 44, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    tick();

    // Reset during beat 1 of a drain, after sat_flag has been set
    do_reset();
    send(1'b1, row(100, -100, 5, 0));
    send(1'b0, row(100, -100, 5, 0));
    tick();
    tick();
    tick();
    tick();
    check("mr_sat_pre", int'(sat_flag), 1);
    send(1'b1, row(1, 2, 3, 4));
    send(1'b0, row(10, 20, 30, 40));
    tick();
    beat("mr_b1", 33, 1'b0, 1'b0);
    res = 1'b1;
    tick();
    res = 1'b0;
    check("mr_valid", int'(out_valid), 0);
    check("mr_sat", int'(sat_flag), 0);
    check("mr_ready", int'(in_ready), 1);
    tick();
    check("mr_valid2", int'(out_valid), 0);
    send(1'b1, row(1, 2, 3, 4));
    send(1'b0, row(5, 5, 5, 5));
    beat("mr_new_b0", 9, 1'b1, 1'b0);
    tick();
    beat("mr_new_b1", 8, 1'b0, 1'b0);
    tick();
    beat("mr_new_b2", 7, 1'b0, 1'b0);
    tick();
    beat("mr_new_b3", 6, 1'b0, 1'b1);
    tick();
    check("mr_new_end", int'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_sum_acc.md
SYS_SUM_ACC -- requirements
Module: sys_sum_acc

Interface
REQ-001 SHALL have parameter BitSize, default 8: signed width of input and output elements.
REQ-002 SHALL have parameter AccSize, default 16: signed accumulator width; AccSize >= BitSize + $clog2(DepthIn).
REQ-003 SHALL have parameter NumOfNerves, default 4: channels summed in parallel.
REQ-004 SHALL have parameter DepthIn, default 2: rows per group, >= 1.
REQ-005 SHALL have parameter OutLanes, default 1: elements per output beat; NumOfNerves divisible by OutLanes.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all logic on posedge.
REQ-007 SHALL have port res, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1 bit: a row is presented.
REQ-009 SHALL have port in_start, input, 1 bit: marks the first row of a group.
REQ-010 SHALL have port in_data, input, [NumOfNerves-1:0][BitSize-1:0]: signed row elements.
REQ-011 SHALL have port in_ready, output, 1 bit: a row is accepted when in_valid && in_ready.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the current beat.
REQ-013 SHALL have port out_valid, output, 1 bit: a beat is presented.
REQ-014 SHALL have port out_start, output, 1 bit: marks the first beat of a group.
REQ-015 SHALL have port out_last, output, 1 bit: marks the last beat of a group.
REQ-016 SHALL have port out_data, output, [OutLanes-1:0][BitSize-1:0]: saturated sums.
REQ-017 SHALL have port sat_flag, output, 1 bit: sticky; set once any element has saturated.

Function
REQ-018 SHALL sign-extend each in_data element to AccSize and add it into acc[i] on every accepted row.
REQ-019 SHALL, on an accepted row with in_start=1, load acc[i] = in_data[i] and set the row count to 1, discarding any partial group.
REQ-020 SHALL drop an accepted row with in_start=0 when the row count is 0, leaving acc and the count unchanged.
REQ-021 SHALL treat the group as complete on the DepthIn-th accepted row; with DepthIn=1, a single in_start row completes the group.
REQ-022 SHALL have an input FSM with states ACC and HOLD; in_ready = (state == ACC).
REQ-023 SHALL define "shadow free" as !out_valid || (out_valid && out_ready && out_last).
REQ-024 SHALL, on completion when shadow is free, write the final sums into the shadow buffer at that same edge, reset the row count to 0 and stay in ACC.
REQ-025 SHALL, on completion when shadow is busy, keep the sums in acc and enter HOLD.
REQ-026 SHALL, in HOLD when shadow becomes free, copy acc to shadow at that edge, clear the row count and return to ACC.
REQ-027 SHALL have an output FSM with states IDLE and DRAIN and a beat counter b in 0..NumOfNerves/OutLanes-1; a shadow load moves it to DRAIN with b=0.
REQ-028 SHALL assert out_valid one cycle after the completing row is accepted, or one cycle after the HOLD transfer.
REQ-029 SHALL drive out_data[j] at beat b with the element of nerve index NumOfNerves-1-(b*OutLanes+j), so the highest nerve is emitted first.
REQ-030 SHALL clamp each element to [-2^(BitSize-1), 2^(BitSize-1)-1]; sat_flag is set on the cycle a clamped beat is presented.
REQ-031 SHALL assert out_start at b=0 and out_last at b=NumOfNerves/OutLanes-1, both gated by out_valid.
REQ-032 SHALL hold out_data, out_start and out_last stable while out_valid && !out_ready.
REQ-033 SHALL increment b on each handshake; the last handshake goes to IDLE unless a new shadow load occurs at the same edge.
REQ-034 SHALL sustain back-to-back groups with no in_ready deassertion when NumOfNerves/OutLanes <= DepthIn and out_ready=1.

Reset
REQ-035 SHALL, while res=1 at a clock edge, clear acc, shadow, row count and b, set both FSMs to ACC/IDLE, and clear sat_flag.
REQ-036 SHALL present out_valid=0, out_start=0, out_last=0, out_data=0 and in_ready=1 from the cycle after reset.
REQ-037 SHALL, on reset mid-group or mid-drain, discard all data with no partial output.

Verification (BitSize=8, AccSize=16, NumOfNerves=4, DepthIn=2 unless noted)
REQ-038 SHALL cover basic: rows [1,2,3,4] (start) then [10,20,30,40], out_ready=1 -> beats 44,33,22,11 on 4 consecutive cycles starting 1 cycle after row 2; out_start on 44, out_last on 11.
REQ-039 SHALL cover saturation: rows [100,-100,5,0] twice -> beats 0,10,-128,127; sat_flag=1 and stays 1.
REQ-040 SHALL cover backpressure: out_ready=0 while two groups are sent -> the first beat is held stable, in_ready=0 after group 2 completes, and in_ready=1 the cycle after the group-1 out_last handshake; group 2 then drains intact.
REQ-041 SHALL cover restart: [1,1,1,1] (start), [2,2,2,2] (start), [3,3,3,3] -> beats 5,5,5,5; a start-less row while idle produces no output.
REQ-042 SHALL cover OutLanes=2 with the REQ-038 stimulus -> beat0 {44,33} with start, beat1 {22,11} with last.
REQ-043 SHALL cover res=1 for one cycle during the beat-1 drain -> out_valid=0 next cycle, sat_flag=0, and a fresh group then produces correct sums.
